// File: rtl/qarma_lfsr_stepper.sv
// Multi-step bidirectional cell-LFSR engine for the QARMA tweak schedule.
// Applies in_steps forward or inverse LFSR updates (one per clock) to the masked cells.
module qarma_lfsr_stepper #(
    parameter int                 CELL_W    = 8,
    parameter int                 NCELLS    = 16,
    parameter logic [NCELLS-1:0]  CELL_MASK = 16'h291B,
    parameter int                 TAP       = 2,
    parameter int                 CNT_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NCELLS*CELL_W-1:0]   in_data,
    input  logic [CNT_W-1:0]           in_steps,
    input  logic                       in_inv,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NCELLS*CELL_W-1:0]   out_data,
    output logic                       busy
);

    localparam int W = NCELLS * CELL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [W-1:0]         data_r, data_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 inv_r, inv_s;
    logic                 in_ready_s;

    // One LFSR update on every masked cell; cell 0 sits in the most significant bits.
    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] d, input logic inv);
        logic [W-1:0]      r;
        logic [CELL_W-1:0] x;
        r = d;
        for (int i = 0; i < NCELLS; i++) begin
            x = d[(NCELLS-1-i)*CELL_W +: CELL_W];
            if (CELL_MASK[i]) begin
                if (inv) begin
                    r[(NCELLS-1-i)*CELL_W +: CELL_W] = {x[CELL_W-2:0], x[CELL_W-1] ^ x[TAP-1]};
                end else begin
                    r[(NCELLS-1-i)*CELL_W +: CELL_W] = {x[0] ^ x[TAP], x[CELL_W-1:1]};
                end
            end else begin
                r[(NCELLS-1-i)*CELL_W +: CELL_W] = x;
            end
        end
        return r;
    endfunction

    assign in_ready_s = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    assign in_ready   = in_ready_s;
    assign out_valid  = (state_r == DONE);
    assign busy       = (state_r == RUN);
    assign out_data   = data_r;

    // Next-state logic; DONE with out_ready reloads directly so back-to-back requests see no bubble.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        cnt_s   = cnt_r;
        inv_s   = inv_r;
        case (state_r)
            IDLE, DONE: begin
                if (in_valid && in_ready_s) begin
                    data_s  = in_data;
                    inv_s   = in_inv;
                    cnt_s   = in_steps;
                    state_s = (in_steps != {CNT_W{1'b0}}) ? RUN : DONE;
                end else if (state_r == DONE && out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                data_s = lfsr_step(data_r, inv_r);
                cnt_s  = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            data_r  <= {W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            inv_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            cnt_r   <= cnt_s;
            inv_r   <= inv_s;
        end
    end

endmodule

// File: tb/tb_qarma_lfsr_stepper.sv
// Self-checking bench for qarma_lfsr_stepper (qarma128 build): vector table,
// handshake corner sequences and randomized round trips against a cell-level model.
module tb_qarma_lfsr_stepper;

    localparam int CW = 8;
    localparam int NC = 16;
    localparam int TP = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data;
    logic [3:0]   in_steps;

    int n_checks = 0;
    int n_fail   = 0;

    qarma_lfsr_stepper #(
        .CELL_W(8), .NCELLS(16), .CELL_MASK(16'h291B), .TAP(2), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_steps(in_steps), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each listed cell is a CW-bit integer shifted right (forward) or left (inverse).
    function automatic logic [127:0] model(input logic [127:0] d, input int steps, input bit inv);
        int cells[7] = '{0, 1, 3, 4, 8, 11, 13};
        logic [127:0] w;
        int x, nx, sh;
        w = d;
        for (int k = 0; k < steps; k++) begin
            for (int j = 0; j < 7; j++) begin
                sh = (NC - 1 - cells[j]) * CW;
                x  = int'((w >> sh) & 128'hFF);
                if (inv) nx = ((x << 1) & 255) | (((x >> (CW - 1)) ^ (x >> (TP - 1))) & 1);
                else     nx = (x >> 1) | (((x ^ (x >> TP)) & 1) << (CW - 1));
                w = (w & ~(128'hFF << sh)) | (128'(nx) << sh);
            end
        end
        return w;
    endfunction

    task automatic send(input logic [127:0] d, input logic [3:0] s, input logic inv);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_timeout", 128'(in_ready), 128'd1);
        in_valid = 1'b1; in_data = d; in_steps = s; in_inv = inv;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        check("out_valid_timeout", 128'(out_valid), 128'd1);
    endtask

    task automatic take(output logic [127:0] r);
        r = out_data;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input logic [127:0] d, input logic [3:0] s, input logic inv,
                       output logic [127:0] r, output int lat);
        send(d, s, inv);
        wait_valid(lat);
        take(r);
    endtask

    typedef struct {
        logic [127:0] d;
        logic [3:0]   s;
        logic         inv;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t         vecs[8];
    vec_t         b2b[3];
    logic [127:0] r, b, dd, expq[3];
    int           lat, idx, got, last_take;
    logic         acc, tk;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_steps = '0; in_inv = 1'b0; out_ready = 1'b0;

        vecs[0] = '{128'h01 << 120, 4'd1,  1'b0, 128'h80 << 120, 2};
        vecs[1] = '{128'h05 << 120, 4'd1,  1'b0, 128'h02 << 120, 2};
        vecs[2] = '{128'h01 << 104, 4'd15, 1'b0, 128'h01 << 104, 16};
        vecs[3] = '{128'h80 << 120, 4'd1,  1'b1, 128'h01 << 120, 2};
        vecs[4] = '{128'h0,         4'd15, 1'b0, 128'h0,         16};
        vecs[5] = '{128'h0123456789abcdef_fedcba9876543210, 4'd0, 1'b1,
                    128'h0123456789abcdef_fedcba9876543210, 1};
        vecs[6] = '{(128'h01 << 112) | 128'hFF, 4'd1, 1'b0, (128'h80 << 112) | 128'hFF, 2};
        vecs[7] = '{128'h01 << 16,  4'd2,  1'b0, 128'h40 << 16,  3};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed vector table
        for (int i = 0; i < 8; i++) begin
            run(vecs[i].d, vecs[i].s, vecs[i].inv, r, lat);
            check($sformatf("vec%0d_data", i), r, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), 128'(lat), 128'(vecs[i].lat));
        end

        // reset in the middle of a 5-step run
        dd = {$urandom, $urandom, $urandom, $urandom};
        send(dd, 4'd5, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("run_busy", 128'(busy), 128'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_out_data", out_data, 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        run(dd, 4'd5, 1'b0, r, lat);
        check("postrst_data", r, model(dd, 5, 1'b0));
        check("postrst_lat", 128'(lat), 128'd6);

        // back-to-back hand-off with out_ready held high
        b2b[0] = '{{$urandom, $urandom, $urandom, $urandom}, 4'd3, 1'b0, 128'h0, 0};
        b2b[1] = '{{$urandom, $urandom, $urandom, $urandom}, 4'd0, 1'b1, 128'h0, 0};
        b2b[2] = '{{$urandom, $urandom, $urandom, $urandom}, 4'd7, 1'b1, 128'h0, 0};
        for (int i = 0; i < 3; i++) expq[i] = model(b2b[i].d, int'(b2b[i].s), b2b[i].inv);
        @(negedge clk);
        out_ready = 1'b1;
        idx = 0; got = 0; last_take = -1;
        in_valid = 1'b1; in_data = b2b[0].d; in_steps = b2b[0].s; in_inv = b2b[0].inv;
        for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            acc = in_valid & in_ready;
            tk  = out_valid & out_ready;
            if (tk) begin
                check($sformatf("b2b_data%0d", got), out_data, expq[got]);
                if (idx < 3) check("b2b_no_bubble", 128'(in_ready), 128'd1);
                got++;
                last_take = cyc;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    in_data = b2b[idx].d; in_steps = b2b[idx].s; in_inv = b2b[idx].inv;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", 128'(got), 128'd3);
        check("b2b_total_cycles", 128'(last_take), 128'd13);

        // backpressure for 10 cycles while a new request waits
        dd = {$urandom, $urandom, $urandom, $urandom};
        send(dd, 4'd2, 1'b1);
        wait_valid(lat);
        in_valid = 1'b1; in_data = ~dd; in_steps = 4'd1; in_inv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_data", out_data, model(dd, 2, 1'b1));
            check("bp_in_ready", 128'(in_ready), 128'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_single_xfer", 128'(out_valid), 128'd0);
        @(negedge clk);
        check("bp_idle_after", 128'(out_valid), 128'd0);
        check("bp_ready_after", 128'(in_ready), 128'd1);

        // randomized forward/inverse round trips
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] s;
            dd = {$urandom, $urandom, $urandom, $urandom};
            s  = 4'($urandom_range(0, 15));
            run(dd, s, 1'b0, r, lat);
            check("rnd_fwd", r, model(dd, int'(s), 1'b0));
            check("rnd_lat", 128'(lat), 128'(int'(s) + 1));
            run(r, s, 1'b1, b, lat);
            check("rnd_roundtrip", b, dd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
